// File: rtl/sr_pkg.sv
// Shared types and defaults for the SR flop bank.
package sr_pkg;

   // How a channel resolves a simultaneous set and reset request
   typedef enum logic [1:0] {
      SET_DOM = 2'd0,
      RST_DOM = 2'd1,
      HOLD    = 2'd2,
      TOGGLE  = 2'd3
   } sr_mode_t;

   localparam int SR_WIDTH = 8;
   localparam int SR_CNT_W = 8;

   // Next value of one channel for an enabled sample
   function automatic logic sr_next(sr_mode_t mode, logic s, logic r, logic q);
      logic nxt;
      nxt = q;
      case ({s, r})
         2'b10:   nxt = 1'b1;
         2'b01:   nxt = 1'b0;
         2'b11: begin
            case (mode)
               SET_DOM: nxt = 1'b1;
               RST_DOM: nxt = 1'b0;
               HOLD:    nxt = q;
               TOGGLE:  nxt = ~q;
               default: nxt = q;
            endcase
         end
         default: nxt = q;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/sr_flop_bank_if.sv
// Request/status bundle between the SR flop bank and its user.
interface sr_flop_bank_if
   import sr_pkg::*;
#(
   parameter int WIDTH = SR_WIDTH,
   parameter int CNT_W = SR_CNT_W
);
   logic             en;
   logic [WIDTH-1:0] S;
   logic [WIDTH-1:0] R;
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] Qbar;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic             conflict;
   logic [CNT_W-1:0] conflict_cnt;

   // Driver side: issues set/reset requests, observes state
   modport master (
      output en, S, R,
      input  Q, Qbar, rise, fall, conflict, conflict_cnt
   );

   // Flop bank side
   modport slave (
      input  en, S, R,
      output Q, Qbar, rise, fall, conflict, conflict_cnt
   );
endinterface

// File: rtl/sr_flop_cell.sv
// One SR channel: resolve S/R, hold Q, and flag edges of Q.
module sr_flop_cell
   import sr_pkg::*;
#(
   parameter sr_mode_t MODE     = SET_DOM,
   parameter logic     INIT_BIT = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   input  logic i_s,
   input  logic i_r,
   output logic o_q,
   output logic o_rise,
   output logic o_fall
);
   logic r_q;
   logic r_rise;
   logic r_fall;
   logic w_nxt;

   // Resolve the sampled request against the current state
   always_comb begin
      w_nxt = sr_next(MODE, i_s, i_r, r_q);
   end

   // State and edge flags; edge flags line up with the cycle Q shows its new value
   always_ff @(posedge clk) begin
      if (reset) begin
         r_q    <= INIT_BIT;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else if (i_en) begin
         r_q    <= w_nxt;
         r_rise <= ~r_q & w_nxt;
         r_fall <= r_q & ~w_nxt;
      end else begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end
   end

   assign o_q    = r_q;
   assign o_rise = r_rise;
   assign o_fall = r_fall;
endmodule

// File: rtl/sr_flop_bank.sv
// Bank of independent clocked SR channels with shared conflict tracking.
module sr_flop_bank
   import sr_pkg::*;
#(
   parameter int               WIDTH = SR_WIDTH,
   parameter sr_mode_t         MODE  = SET_DOM,
   parameter logic [WIDTH-1:0] INIT  = '0,
   parameter int               CNT_W = SR_CNT_W
) (
   input logic          clk,
   input logic          reset,
   sr_flop_bank_if.slave bus
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] w_q;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;
   logic             w_conf;
   logic             r_conflict;
   logic [CNT_W-1:0] r_cnt;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      sr_flop_cell #(
         .MODE     (MODE),
         .INIT_BIT (INIT[i])
      ) u_cell (
         .clk    (clk),
         .reset  (reset),
         .i_en   (bus.en),
         .i_s    (bus.S[i]),
         .i_r    (bus.R[i]),
         .o_q    (w_q[i]),
         .o_rise (w_rise[i]),
         .o_fall (w_fall[i])
      );
   end

   // Any channel seeing S=R=1 on an enabled sample is one conflict cycle
   always_comb begin
      w_conf = bus.en & (|(bus.S & bus.R));
   end

   // Conflict pulse and saturating conflict counter
   always_ff @(posedge clk) begin
      if (reset) begin
         r_conflict <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_conflict <= w_conf;
         if (w_conf && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // Qbar is derived from the flop output so it is never equal to Q
   assign bus.Q            = w_q;
   assign bus.Qbar         = ~w_q;
   assign bus.rise         = w_rise;
   assign bus.fall         = w_fall;
   assign bus.conflict     = r_conflict;
   assign bus.conflict_cnt = r_cnt;
endmodule

// File: tb/tb_sr_flop_bank.sv
// Directed bench: four banks (one per S=R=1 mode) share the same stimulus.
module tb_sr_flop_bank;
   import sr_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic [3:0] S;
   logic [3:0] R;
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   sr_flop_bank_if #(.WIDTH(4), .CNT_W(3)) b_sd ();
   sr_flop_bank_if #(.WIDTH(4), .CNT_W(3)) b_rd ();
   sr_flop_bank_if #(.WIDTH(4), .CNT_W(3)) b_hd ();
   sr_flop_bank_if #(.WIDTH(4), .CNT_W(3)) b_tg ();

   assign b_sd.en = en;  assign b_sd.S = S;  assign b_sd.R = R;
   assign b_rd.en = en;  assign b_rd.S = S;  assign b_rd.R = R;
   assign b_hd.en = en;  assign b_hd.S = S;  assign b_hd.R = R;
   assign b_tg.en = en;  assign b_tg.S = S;  assign b_tg.R = R;

   sr_flop_bank #(.WIDTH(4), .MODE(SET_DOM), .INIT(4'b0000), .CNT_W(3))
      u_sd (.clk(clk), .reset(reset), .bus(b_sd));
   sr_flop_bank #(.WIDTH(4), .MODE(RST_DOM), .INIT(4'b0000), .CNT_W(3))
      u_rd (.clk(clk), .reset(reset), .bus(b_rd));
   sr_flop_bank #(.WIDTH(4), .MODE(HOLD), .INIT(4'b0000), .CNT_W(3))
      u_hd (.clk(clk), .reset(reset), .bus(b_hd));
   sr_flop_bank #(.WIDTH(4), .MODE(TOGGLE), .INIT(4'b0000), .CNT_W(3))
      u_tg (.clk(clk), .reset(reset), .bus(b_tg));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Sample one time unit after the active edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] q_exp;

      // Reset state
      reset = 1'b1; en = 1'b1; S = 4'b1111; R = 4'b0000;
      step(); step();
      chk("rst_q",    32'(b_sd.Q), 32'h0);
      chk("rst_qbar", 32'(b_sd.Qbar), 32'hf);
      chk("rst_rise", 32'(b_sd.rise), 32'h0);
      chk("rst_conf", 32'(b_tg.conflict), 32'h0);
      chk("rst_cnt",  32'(b_tg.conflict_cnt), 32'h0);

      // First cycle out of reset with nothing requested: no pulses
      reset = 1'b0; S = 4'b0000;
      step();
      chk("post_rst_rise", 32'(b_sd.rise), 32'h0);
      chk("post_rst_fall", 32'(b_sd.fall), 32'h0);

      // Single set on channel 0
      S = 4'b0001;
      step();
      chk("set_q",    32'(b_sd.Q), 32'h1);
      chk("set_qbar", 32'(b_sd.Qbar), 32'he);
      chk("set_rise", 32'(b_sd.rise), 32'h1);
      S = 4'b0000;
      step();
      chk("hold_q",    32'(b_sd.Q), 32'h1);
      chk("hold_rise", 32'(b_sd.rise), 32'h0);

      // Mode sweep with S=R=1 on channel 0 from Q=0001
      S = 4'b0001; R = 4'b0001;
      step();
      chk("sd_q",    32'(b_sd.Q), 32'h1);
      chk("sd_fall", 32'(b_sd.fall), 32'h0);
      chk("rd_q",    32'(b_rd.Q), 32'h0);
      chk("rd_fall", 32'(b_rd.fall), 32'h1);
      chk("hd_q",    32'(b_hd.Q), 32'h1);
      chk("tg_q",    32'(b_tg.Q), 32'h0);
      chk("sd_conf", 32'(b_sd.conflict), 32'h1);
      chk("rd_conf", 32'(b_rd.conflict), 32'h1);
      chk("hd_conf", 32'(b_hd.conflict), 32'h1);
      chk("sd_cnt",  32'(b_sd.conflict_cnt), 32'h1);

      // Toggle held for four cycles on channel 3
      reset = 1'b1; S = 4'b0000; R = 4'b0000;
      step();
      chk("rst2_tg_q", 32'(b_tg.Q), 32'h0);
      reset = 1'b0; S = 4'b1000; R = 4'b1000;
      for (int k = 1; k <= 4; k++) begin
         step();
         chk($sformatf("tg_q%0d", k),    32'(b_tg.Q),    (k % 2) ? 32'h8 : 32'h0);
         chk($sformatf("tg_rise%0d", k), 32'(b_tg.rise), (k % 2) ? 32'h8 : 32'h0);
         chk($sformatf("tg_fall%0d", k), 32'(b_tg.fall), (k % 2) ? 32'h0 : 32'h8);
         chk($sformatf("tg_conf%0d", k), 32'(b_tg.conflict), 32'h1);
      end
      chk("tg_cnt4", 32'(b_tg.conflict_cnt), 32'h4);
      chk("sd_tq",   32'(b_sd.Q), 32'h8);

      // Enable low: everything holds, no pulses
      en = 1'b0; S = 4'b1111; R = 4'b1111;
      step();
      chk("en0_tg_q",    32'(b_tg.Q), 32'h0);
      chk("en0_sd_q",    32'(b_sd.Q), 32'h8);
      chk("en0_rise",    32'(b_sd.rise), 32'h0);
      chk("en0_conf",    32'(b_tg.conflict), 32'h0);
      chk("en0_cnt",     32'(b_tg.conflict_cnt), 32'h4);

      // Pulse between edges is ignored
      en = 1'b1; S = 4'b0000; R = 4'b0000;
      #2 S = 4'b1111;
      #2 S = 4'b0000;
      step();
      chk("glitch_q", 32'(b_tg.Q), 32'h0);

      // Mixed set/reset across channels from Q=0001
      S = 4'b0001;
      step();
      chk("mix_pre_q", 32'(b_tg.Q), 32'h1);
      S = 4'b0100; R = 4'b0001;
      step();
      chk("mix_q",    32'(b_tg.Q), 32'h4);
      chk("mix_rise", 32'(b_tg.rise), 32'h4);
      chk("mix_fall", 32'(b_tg.fall), 32'h1);
      chk("mix_sd_q", 32'(b_sd.Q), 32'hc);
      chk("mix_conf", 32'(b_tg.conflict), 32'h0);

      // Counter saturation, then reset mid-saturation and mid-toggle
      reset = 1'b1; S = 4'b0000; R = 4'b0000;
      step();
      reset = 1'b0; S = 4'b1111; R = 4'b1111;
      for (int k = 1; k <= 9; k++) begin
         step();
         chk($sformatf("sat_cnt%0d", k), 32'(b_hd.conflict_cnt), (k > 7) ? 32'h7 : 32'(k));
      end
      q_exp = 4'b1111;
      chk("sat_tg_q", 32'(b_tg.Q), 32'(q_exp));
      reset = 1'b1;
      step();
      chk("rst3_cnt",  32'(b_hd.conflict_cnt), 32'h0);
      chk("rst3_q",    32'(b_tg.Q), 32'h0);
      chk("rst3_qbar", 32'(b_tg.Qbar), 32'hf);
      chk("rst3_fall", 32'(b_tg.fall), 32'h0);
      chk("rst3_conf", 32'(b_tg.conflict), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sr_flop_bank.md
SR_FLOP_BANK -- requirements
Module: sr_flop_bank

Interface
REQ-001 Parameter WIDTH, default 8, number of independent SR channels (1..32).
REQ-002 Parameter MODE, default SET_DOM, S=R=1 resolution (sr_pkg::sr_mode_t: SET_DOM, RST_DOM, HOLD, TOGGLE).
REQ-003 Parameter INIT, default all-zero, WIDTH-bit reset value of Q.
REQ-004 Parameter CNT_W, default 8, width of the conflict counter.
REQ-005 The block SHALL use one clock, clk, with a synchronous, active-high reset, reset; all state SHALL change only on the rising edge of clk.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 en  input  1  sample enable; when low, all channel state holds.
REQ-009 S  input  WIDTH  per-channel set request.
REQ-010 R  input  WIDTH  per-channel reset request.
REQ-011 Q  output  WIDTH  registered channel state.
REQ-012 Qbar  output  WIDTH  complement of Q.
REQ-013 rise  output  WIDTH  one-cycle pulse per channel on a Q 0->1 change.
REQ-014 fall  output  WIDTH  one-cycle pulse per channel on a Q 1->0 change.
REQ-015 conflict  output  1  one-cycle pulse when any channel sampled S=R=1 with en high.
REQ-016 conflict_cnt  output  CNT_W  saturating count of conflict cycles.

Function
REQ-017 Per channel i, on a clk edge with en=1: S=1,R=0 -> Q[i]=1; S=0,R=1 -> Q[i]=0; S=0,R=0 -> hold.
REQ-018 For S=R=1 with en=1: SET_DOM -> Q[i]=1; RST_DOM -> Q[i]=0; HOLD -> Q[i] unchanged; TOGGLE -> Q[i]=~Q[i].
REQ-019 Latency: the Q update is visible exactly one clk cycle after S/R are sampled; S and R pulses between edges have no effect.
REQ-020 Qbar SHALL equal ~Q at all times, including during reset, so the illegal Q=Qbar state of an unclocked latch never occurs.
REQ-021 rise[i] and fall[i] SHALL be registered and asserted in the same cycle that Q[i] first shows its new value, for exactly one cycle.
REQ-022 With en=0, Q SHALL hold, rise/fall SHALL be 0, and conflict SHALL be 0 regardless of S and R.
REQ-023 The conflict pulse SHALL be registered and appear in the same cycle as the Q update caused by the conflicting sample; multiple conflicting channels in one cycle count once.
REQ-024 conflict_cnt SHALL increment by 1 per conflict cycle and saturate at 2^CNT_W-1 with no wrap-around.
REQ-025 In TOGGLE mode with S=R=1 held, Q[i] SHALL alternate every enabled cycle, with rise and fall alternating accordingly.
REQ-026 Channels SHALL be fully independent; a simultaneous set on channel a and reset on channel b SHALL both take effect in the same cycle.

Reset
REQ-027 While reset=1 at a clk edge: Q=INIT, Qbar=~INIT, rise=0, fall=0, conflict=0, conflict_cnt=0.
REQ-028 Reset SHALL take priority over en, S and R; no rise/fall pulse SHALL be generated by reset itself or by the first cycle after reset.
REQ-029 Reset asserted mid-toggle or mid-saturation SHALL restore all state within that single edge.

Structure
REQ-030 sr_pkg SHALL hold sr_mode_t and the default WIDTH/CNT_W constants.
REQ-031 A sub-module sr_flop_cell (one channel: next-state logic, Q flop, rise/fall flops) SHALL be instantiated WIDTH times; conflict detection and the counter live in the top level.

Verification (WIDTH=4, CNT_W=3, INIT=4'b0000)
REQ-032 SET_DOM: reset, then S=4'b0001,R=0,en=1 for 1 cycle -> next cycle Q=0001, Qbar=1110, rise=0001; then S=0 -> Q holds 0001, rise=0000.
REQ-033 Mode sweep: S=R=4'b0001 from Q=0001 -> SET_DOM Q=0001; RST_DOM Q=0000 with fall=0001; HOLD Q=0001; conflict=1 in all three.
REQ-034 TOGGLE: S=R=4'b1000 held 4 cycles from Q=0000 -> Q[3] goes 1,0,1,0; rise/fall alternate; conflict_cnt=4.
REQ-035 Saturation: 9 conflict cycles -> conflict_cnt stays at 7 after the 7th; then reset -> 0.
REQ-036 Enable gating: en=0 with S=1111 -> Q unchanged, no pulses; mixed S=0100,R=0001 with en=1 from Q=0001 -> Q=0100, rise=0100, fall=0001.
